// File: rtl/fpu_rf_pkg.sv
// Shared defaults and FSM state type for the FPU register-file read controller.
package fpu_rf_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 36;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_SPLIT,
    S_READ2,
    S_HOLD
  } state_e;

endpackage

// File: rtl/fpu_rf_bypass_cmp.sv
// Per-operand writeback address match and operand source select.
// The priority order is: same-cycle writeback, then the stored issue-cycle forward, then RAM data.
module fpu_rf_bypass_cmp #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 36
) (
  input  logic              fwd_en,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] addr,
  input  logic              fwd_vld,
  input  logic [DATA_W-1:0] fwd_data,
  input  logic [DATA_W-1:0] ram_data,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  always_comb begin
    hit  = wb_valid && (wb_addr == addr);
    data = ram_data;
    if (fwd_en && hit)
      data = wb_data;
    else if (fwd_en && fwd_vld)
      data = fwd_data;
  end

endmodule

// File: rtl/fpu_rf_ctrl.sv
// Operand-fetch controller sharing a dual-port register file with the writeback path.
// Define FPU_RF_BYPASS_EN to forward colliding writebacks instead of stalling the request.
module fpu_rf_ctrl
  import fpu_rf_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_rs1,
  input  logic [ADDR_W-1:0] req_rs2,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              rf_we_a,
  output logic [ADDR_W-1:0] rf_addr_a,
  output logic [DATA_W-1:0] rf_din_a,
  input  logic [DATA_W-1:0] rf_dout_a,
  output logic              rf_we_b,
  output logic [ADDR_W-1:0] rf_addr_b,
  output logic [DATA_W-1:0] rf_din_b,
  input  logic [DATA_W-1:0] rf_dout_b
);

`ifdef FPU_RF_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic              op_valid_q, op_valid_d;
  logic              fwd_a_vld_q, fwd_a_vld_d, fwd_b_vld_q, fwd_b_vld_d;
  logic [DATA_W-1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

  logic              idle, accept, hit_a, hit_b;
  logic [ADDR_W-1:0] cmp_addr_a, cmp_addr_b;
  logic [DATA_W-1:0] data_a, data_b, ram_b;

  assign idle       = (state_q == S_IDLE);
  assign cmp_addr_a = idle ? req_rs1 : rs1_q;
  assign cmp_addr_b = idle ? req_rs2 : rs2_q;
  // op_b comes from port A only on the READ path; the SPLIT path reads it on port B
  assign ram_b      = (state_q == S_READ) ? rf_dout_a : rf_dout_b;

  fpu_rf_bypass_cmp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cmp_a (
    .fwd_en(BYP), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .addr(cmp_addr_a), .fwd_vld(fwd_a_vld_q), .fwd_data(fwd_a_q),
    .ram_data(rf_dout_b), .hit(hit_a), .data(data_a)
  );

  fpu_rf_bypass_cmp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cmp_b (
    .fwd_en(BYP), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .addr(cmp_addr_b), .fwd_vld(fwd_b_vld_q), .fwd_data(fwd_b_q),
    .ram_data(ram_b), .hit(hit_b), .data(data_b)
  );

  // Without forwarding a colliding writeback must land before the read is issued
  assign req_ready = !rst && idle && !(!BYP && (hit_a || hit_b));
  assign accept    = req_valid && req_ready;

  assign rf_we_a   = wb_valid && !rst;
  assign rf_addr_a = wb_valid ? wb_addr : (idle ? req_rs2 : rs2_q);
  assign rf_din_a  = wb_data;
  assign rf_we_b   = 1'b0;
  assign rf_din_b  = '0;
  assign rf_addr_b = (state_q == S_SPLIT) ? rs2_q : (idle ? req_rs1 : rs1_q);

  assign op_valid  = op_valid_q;
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;

  always_comb begin
    state_d     = state_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_valid_d  = op_valid_q;
    fwd_a_vld_d = fwd_a_vld_q;
    fwd_a_d     = fwd_a_q;
    fwd_b_vld_d = fwd_b_vld_q;
    fwd_b_d     = fwd_b_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          rs1_d       = req_rs1;
          rs2_d       = req_rs2;
          fwd_a_vld_d = hit_a;
          fwd_a_d     = wb_data;
          fwd_b_vld_d = 1'b0;
          state_d     = wb_valid ? S_SPLIT : S_READ;
        end
      end
      S_READ: begin
        op_a_d     = data_a;
        op_b_d     = data_b;
        op_valid_d = 1'b1;
        state_d    = S_HOLD;
      end
      S_SPLIT: begin
        op_a_d      = data_a;
        fwd_b_vld_d = hit_b;
        fwd_b_d     = wb_data;
        state_d     = S_READ2;
      end
      S_READ2: begin
        op_b_d     = data_b;
        op_valid_d = 1'b1;
        state_d    = S_HOLD;
      end
      S_HOLD: begin
        if (op_ready) begin
          op_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rs1_q       <= '0;
      rs2_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_valid_q  <= 1'b0;
      fwd_a_vld_q <= 1'b0;
      fwd_a_q     <= '0;
      fwd_b_vld_q <= 1'b0;
      fwd_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_valid_q  <= op_valid_d;
      fwd_a_vld_q <= fwd_a_vld_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_vld_q <= fwd_b_vld_d;
      fwd_b_q     <= fwd_b_d;
    end
  end

endmodule

// File: tb/tb_fpu_rf_ctrl.sv
// Scoreboard bench for fpu_rf_ctrl: operands are predicted as register contents as of a
// given cycle, which depends on the read path and whether FPU_RF_BYPASS_EN is defined.
module tb_fpu_rf_ctrl;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 36;
`ifdef FPU_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_ready, wb_valid, op_valid, op_ready;
  logic [ADDR_W-1:0] req_rs1, req_rs2, wb_addr, rf_addr_a, rf_addr_b;
  logic [DATA_W-1:0] wb_data, op_a, op_b, rf_din_a, rf_din_b;
  logic [DATA_W-1:0] rf_dout_a, rf_dout_b;
  logic rf_we_a, rf_we_b;

  fpu_rf_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .rf_we_a(rf_we_a), .rf_addr_a(rf_addr_a), .rf_din_a(rf_din_a), .rf_dout_a(rf_dout_a),
    .rf_we_b(rf_we_b), .rf_addr_b(rf_addr_b), .rf_din_b(rf_din_b), .rf_dout_b(rf_dout_b)
  );

  always #5 clk = ~clk;

  // Dual-port register file, read-before-write, one-cycle read latency
  logic [DATA_W-1:0] ram [0:511];
  always @(posedge clk) begin
    if (rf_we_a) ram[rf_addr_a] <= rf_din_a;
    rf_dout_a <= ram[rf_addr_a];
    rf_dout_b <= ram[rf_addr_b];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    int                vcyc;
  } exp_t;

  exp_t              sb_q[$];
  logic [DATA_W-1:0] ref_mem [0:511];
  int   n_chk = 0, n_err = 0, n_acc = 0;
  bit   busy = 0, pend = 0, got_a = 0, got_b = 0, was_valid = 0;
  int   p_ca, p_cb, p_vcyc;
  logic [ADDR_W-1:0] p_rs1, p_rs2;
  logic [DATA_W-1:0] p_a, p_b, last_a, last_b;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd36();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DATA_W-1:0];
  endfunction

  // One clock cycle of stimulus; the model tracks which register snapshot each operand sees.
  task automatic step(input logic v, input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2,
                      input logic wv, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                      input logic ordy);
    bit exp_rdy, split;
    @(negedge clk);
    req_valid = v; req_rs1 = r1; req_rs2 = r2;
    wb_valid = wv; wb_addr = wa; wb_data = wd; op_ready = ordy;
    #1;
    exp_rdy = !busy && !(!BYP && wv && (wa == r1 || wa == r2));
    chk("req_ready", req_ready, exp_rdy);
    chk("rf_we_a", rf_we_a, wv);
    if (v && req_ready) begin
      n_acc++;
      busy  = 1; pend = 1; got_a = 0; got_b = 0;
      split = wv;
      p_rs1 = r1; p_rs2 = r2;
      p_ca   = BYP ? cyc + 1 : cyc - 1;
      p_cb   = split ? (BYP ? cyc + 2 : cyc) : (BYP ? cyc + 1 : cyc - 1);
      p_vcyc = cyc + (split ? 3 : 2);
      if (p_ca == cyc - 1) begin p_a = ref_mem[r1]; got_a = 1; end
      if (p_cb == cyc - 1) begin p_b = ref_mem[r2]; got_b = 1; end
    end
    if (wv) ref_mem[wa] = wd;
    if (pend) begin
      if (!got_a && p_ca == cyc) begin p_a = ref_mem[p_rs1]; got_a = 1; end
      if (!got_b && p_cb == cyc) begin p_b = ref_mem[p_rs2]; got_b = 1; end
      if (got_a && got_b) begin
        sb_q.push_back('{a: p_a, b: p_b, vcyc: p_vcyc});
        pend = 0;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || pend || sb_q.size() != 0) && n < 12) begin
      step(0, 0, 0, 0, 0, 0, 1);
      n++;
    end
    chk("drain_idle", {62'd0, busy, (sb_q.size() != 0)}, 64'd0);
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    rst = 1; req_valid = 0; op_ready = 0;
    wb_valid = 1; wb_addr = 9'd4; wb_data = 36'h1_2345_6789;
    #1;
    chk("rst_op_valid", op_valid, 0);
    chk("rst_op_a", op_a, 0);
    chk("rst_op_b", op_b, 0);
    chk("rst_we_a", rf_we_a, 0);
    sb_q.delete(); busy = 0; pend = 0;
    repeat (hold) @(negedge clk);
    #1;
    chk("rst_hold_op_valid", op_valid, 0);
    rst = 0; wb_valid = 0;
    #1;
    chk("ready_after_rst", req_ready, 1);
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        was_valid = 0;
      end else if (op_valid) begin
        chk("ready_in_hold", req_ready, 0);
        if (sb_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL op_valid_unexpected: got op_valid=1, expected 0 (cycle %0d)", cyc);
        end else begin
          if (!was_valid) chk("latency", cyc, sb_q[0].vcyc);
          chk("op_a", op_a, sb_q[0].a);
          chk("op_b", op_b, sb_q[0].b);
          if (op_ready) begin
            last_a = op_a; last_b = op_b;
            void'(sb_q.pop_front());
            busy = 0;
          end
        end
        was_valid = !op_ready;
      end else begin
        was_valid = 0;
      end
    end
  end

  initial begin : stim
    int a0;
    logic [DATA_W-1:0] d;
    rst = 1; req_valid = 0; req_rs1 = 0; req_rs2 = 0; op_ready = 0;
    wb_valid = 1; wb_addr = 9'd3; wb_data = 36'h0_DEAD_BEEF;
    repeat (2) @(negedge clk);
    #1;
    chk("init_op_valid", op_valid, 0);
    chk("init_op_a", op_a, 0);
    chk("init_op_b", op_b, 0);
    chk("init_we_a", rf_we_a, 0);
    chk("we_b_tied", rf_we_b, 0);
    chk("din_b_tied", rf_din_b, 0);
    rst = 0; wb_valid = 0;
    step(0, 0, 0, 0, 0, 0, 0);

    // Preload every register through the writeback port
    for (int i = 0; i < 512; i++) begin
      d = (i == 5) ? 36'h0_3F800000 : (i == 6) ? 36'h0_40000000 : rnd36();
      step(0, 9'd511, 9'd511, 1, i[ADDR_W-1:0], d, 0);
    end

    // Plain READ path
    step(1, 5, 6, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    drain();
    chk("r5r6_a", last_a, 36'h0_3F800000);
    chk("r5r6_b", last_b, 36'h0_40000000);

    // SPLIT path with an unrelated writeback, then read the written register back
    step(1, 5, 6, 1, 9, 36'h0_1111_2222, 1);
    drain();
    chk("split_a", last_a, 36'h0_3F800000);
    chk("split_b", last_b, 36'h0_40000000);
    step(1, 9, 9, 0, 0, 0, 1);
    drain();
    chk("r9_written", last_a, 36'h0_1111_2222);

    // Same-cycle writeback to rs1
    step(1, 7, 8, 1, 7, 36'h0_C0A00000, 1);
    if (!BYP) step(1, 7, 8, 0, 0, 0, 1);
    drain();
    chk("r7_fwd", last_a, 36'h0_C0A00000);

    // Stall in HOLD while r5 is overwritten
    step(1, 5, 6, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 5, rnd36(), 0);
    drain();
    chk("hold_stable_a", last_a, 36'h0_3F800000);

    // Reset while the SPLIT path is in READ2
    step(1, 5, 6, 1, 9, rnd36(), 0);
    step(0, 0, 0, 0, 0, 0, 0);
    do_reset(2);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1);

    // Back-to-back identical sources
    a0 = n_acc;
    for (int i = 0; i < 9; i++) step(1, 511, 511, 0, 0, 0, 1);
    chk("b2b_accepts", n_acc - a0, 3);
    drain();
    chk("r511_same", last_a, last_b);

    // Random traffic concentrated on a few registers to provoke collisions
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0, 9'($urandom_range(0, 7)), 9'($urandom_range(0, 7)),
           $urandom_range(0, 1) == 1, 9'($urandom_range(0, 9)), rnd36(),
           $urandom_range(0, 3) != 0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_rf_ctrl.md
FPU_RF_CTRL -- requirements
Module: fpu_rf_ctrl

Interface
REQ-001 Parameter ADDR_W, default 9, register-file address width (512 entries).
REQ-002 Parameter DATA_W, default 36, register word width (32 data + 4 parity/tag bits).
REQ-003 clk  in  1  single clock; drives this block and both register-file ports.
REQ-004 rst  in  1  reset; asynchronous and active-high.
REQ-005 req_valid/req_ready  in/out  1/1  operand-read request handshake.
REQ-006 req_rs1, req_rs2  in  ADDR_W  source register addresses.
REQ-007 wb_valid  in  1; wb_addr  in  ADDR_W; wb_data  in  DATA_W  result writeback, always accepted, no ready.
REQ-008 op_valid/op_ready  out/in  1/1  operand-pair handshake to the FPU datapath.
REQ-009 op_a, op_b  out  DATA_W  operands read from rs1 and rs2.
REQ-010 rf_we_a, rf_addr_a, rf_din_a  out  1/ADDR_W/DATA_W  register-file port A (write plus rs2 read).
REQ-011 rf_dout_a  in  DATA_W  port A read data, one-cycle registered latency.
REQ-012 rf_we_b, rf_addr_b, rf_din_b  out  1/ADDR_W/DATA_W  port B (read only); rf_we_b tied 0, rf_din_b tied 0.
REQ-013 rf_dout_b  in  DATA_W  port B read data, one-cycle latency.

Function
REQ-014 Writeback shall own port A combinationally: wb_valid=1 -> rf_we_a=1, rf_addr_a=wb_addr, rf_din_a=wb_data in the same cycle.
REQ-015 States: IDLE, READ, SPLIT, READ2, HOLD.
REQ-016 req_ready shall be 1 only in IDLE; acceptance = req_valid & req_ready.
REQ-017 On acceptance, rf_addr_b=req_rs1; rs1/rs2 latched; if wb_valid=0, rf_addr_a=req_rs2 and next state READ, else next state SPLIT.
REQ-018 READ: op_a <= rf_dout_b, op_b <= rf_dout_a; next HOLD.
REQ-019 SPLIT: op_a <= rf_dout_b; rf_addr_b=latched rs2; next READ2.
REQ-020 READ2: op_b <= rf_dout_b; next HOLD.
REQ-021 HOLD: op_valid=1; op_a/op_b stable; op_ready=1 -> IDLE, else remain.
REQ-022 Latency acceptance->op_valid: 2 cycles (READ path), 3 cycles (SPLIT path); peak throughput one pair per 3 cycles.
REQ-023 rs1==rs2 shall be legal and return identical operands.
REQ-024 A write to an address whose read is issued in the same cycle (cross-port collision) is governed by REQ-029/030.
REQ-025 Writes during HOLD shall not alter op_a/op_b.

Reset
REQ-026 rst=1 shall force state IDLE, op_valid=0, op_a=op_b=0, latched addresses 0, rf_we_a=0 regardless of wb_valid.
REQ-027 Reset mid-operation shall discard the in-flight request without emitting op_valid.
REQ-028 req_ready shall be 1 in the first cycle after rst deasserts.

Configuration
REQ-029 Macro FPU_RF_BYPASS_EN defined: at issue and capture cycles (IDLE accept, READ, SPLIT, READ2), wb_valid with wb_addr equal to the operand's address shall substitute wb_data for that operand (issue-cycle match wins over RAM data; capture-cycle match wins over rf_dout).
REQ-030 FPU_RF_BYPASS_EN undefined: no forwarding; req_ready shall be 0 in IDLE whenever wb_valid=1 and wb_addr equals req_rs1 or req_rs2; capture-cycle writes leave old RAM data in the operand.

Structure
REQ-031 Package fpu_rf_pkg shall hold ADDR_W/DATA_W defaults and the state enumeration type.
REQ-032 Address-match/forward-select logic shall be one sub-module, fpu_rf_bypass_cmp, instantiated per operand.

Verification
REQ-033 Preload r5=36'h0_3F800000, r6=36'h0_40000000; request rs1=5, rs2=6, no writes -> op_valid 2 cycles later, op_a=36'h0_3F800000, op_b=36'h0_40000000.
REQ-034 Request rs1=5, rs2=6 with concurrent wb to r9 -> SPLIT path, op_valid 3 cycles later, correct operands, r9 written.
REQ-035 BYPASS_EN: request rs1=7 with same-cycle wb r7=36'h0_C0A00000 -> op_a=36'h0_C0A00000; without macro req_ready=0 that cycle, accepted next cycle with same result.
REQ-036 op_ready held 0 for 5 cycles in HOLD with writes to r5 -> op_a unchanged, req_ready 0 throughout.
REQ-037 rst asserted in READ2 -> op_valid stays 0, state IDLE, req_ready=1 the cycle after release.
REQ-038 Back-to-back requests rs1=rs2=511 -> both operands equal r511 contents, one pair per 3 cycles.
